// File: rtl/sci_master_if.sv
// sci_master_if: host-side request/completion bundle for sci_master.
// master drives VALID/WNR/ADDR/WDATA; slave returns READY/DONE/RDATA/ERR.
interface sci_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  HOST_VALID;
  logic                  HOST_READY;
  logic                  HOST_WNR;
  logic [ADDR_WIDTH-1:0] HOST_ADDR;
  logic [DATA_WIDTH-1:0] HOST_WDATA;
  logic                  HOST_DONE;
  logic [DATA_WIDTH-1:0] HOST_RDATA;
  logic                  HOST_ERR;

  modport master (
    output HOST_VALID, HOST_WNR,
    output HOST_ADDR, HOST_WDATA,
    input  HOST_READY, HOST_DONE,
    input  HOST_RDATA, HOST_ERR
  );

  modport slave (
    input  HOST_VALID, HOST_WNR,
    input  HOST_ADDR, HOST_WDATA,
    output HOST_READY, HOST_DONE,
    output HOST_RDATA, HOST_ERR
  );
endinterface

// File: rtl/sci_master.sv
// sci_master: SCI initiator; serialises one host read/write per frame.
// Ports: CLK, RSTN (sync, active-low), host (sci_master_if.slave),
// SCI_CSN/SCI_REQ out, SCI_RESP/SCI_ACK in (sampled once before use).
module sci_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int GAP_CYCLES     = 4
) (
  input  logic         CLK,
  input  logic         RSTN,
  sci_master_if.slave  host,
  output logic         SCI_CSN,
  output logic         SCI_REQ,
  input  logic         SCI_RESP,
  input  logic         SCI_ACK
);
  localparam int MAXW =
    (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int BW = $clog2(MAXW) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [BW-1:0] A_LAST = BW'(ADDR_WIDTH - 1);
  localparam logic [BW-1:0] D_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WDATA, WACK, RDATA, GAP
  } state_t;

  state_t                state;
  logic                  ack_q;
  logic                  resp_q;
  logic                  wnr_q;
  logic [ADDR_WIDTH-1:0] addr_sh;
  logic [DATA_WIDTH-1:0] data_sh;
  logic [DATA_WIDTH-1:0] rd_sh;
  logic [BW-1:0]         bcnt;
  logic [TW-1:0]         tcnt;
  logic [GW-1:0]         gcnt;

  // SCI outputs lag the state by one edge, so the frame starts
  // the cycle after the state leaves IDLE.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state           <= IDLE;
      ack_q           <= 1'b0;
      resp_q          <= 1'b0;
      wnr_q           <= 1'b0;
      addr_sh         <= '0;
      data_sh         <= '0;
      rd_sh           <= '0;
      bcnt            <= '0;
      tcnt            <= '0;
      gcnt            <= '0;
      SCI_CSN         <= 1'b1;
      SCI_REQ         <= 1'b0;
      host.HOST_READY <= 1'b1;
      host.HOST_DONE  <= 1'b0;
      host.HOST_ERR   <= 1'b0;
      host.HOST_RDATA <= '0;
    end else begin
      ack_q          <= SCI_ACK;
      resp_q         <= SCI_RESP;
      host.HOST_DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (host.HOST_VALID && host.HOST_READY) begin
            wnr_q           <= host.HOST_WNR;
            addr_sh         <= host.HOST_ADDR;
            data_sh         <= host.HOST_WDATA;
            host.HOST_READY <= 1'b0;
            state           <= CMD;
          end
        end
        CMD: begin
          SCI_CSN <= 1'b0;
          SCI_REQ <= wnr_q;
          bcnt    <= '0;
          state   <= ADDR;
        end
        ADDR: begin
          SCI_REQ <= addr_sh[ADDR_WIDTH-1];
          addr_sh <= addr_sh << 1;
          bcnt    <= bcnt + BW'(1);
          if (bcnt == A_LAST) begin
            bcnt  <= '0;
            tcnt  <= '0;
            rd_sh <= '0;
            state <= wnr_q ? WDATA : RDATA;
          end
        end
        WDATA: begin
          SCI_REQ <= data_sh[DATA_WIDTH-1];
          data_sh <= data_sh << 1;
          bcnt    <= bcnt + BW'(1);
          if (bcnt == D_LAST) begin
            bcnt  <= '0;
            tcnt  <= '0;
            state <= WACK;
          end
        end
        WACK: begin
          SCI_REQ <= 1'b0;
          // ack is tested first so it wins over a limit hit
          if (ack_q) begin
            SCI_CSN        <= 1'b1;
            host.HOST_DONE <= 1'b1;
            host.HOST_ERR  <= 1'b0;
            gcnt           <= '0;
            state          <= GAP;
          end else if (tcnt == T_MAX) begin
            SCI_CSN        <= 1'b1;
            host.HOST_DONE <= 1'b1;
            host.HOST_ERR  <= 1'b1;
            gcnt           <= '0;
            state          <= GAP;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        RDATA: begin
          SCI_REQ <= 1'b0;
          if (ack_q) begin
            rd_sh <= {rd_sh[DATA_WIDTH-2:0], resp_q};
            tcnt  <= '0;
            bcnt  <= bcnt + BW'(1);
            if (bcnt == D_LAST) begin
              SCI_CSN         <= 1'b1;
              host.HOST_DONE  <= 1'b1;
              host.HOST_ERR   <= 1'b0;
              host.HOST_RDATA <= {rd_sh[DATA_WIDTH-2:0], resp_q};
              bcnt            <= '0;
              gcnt            <= '0;
              state           <= GAP;
            end
          end else if (tcnt == T_MAX) begin
            SCI_CSN         <= 1'b1;
            host.HOST_DONE  <= 1'b1;
            host.HOST_ERR   <= 1'b1;
            host.HOST_RDATA <= '0;
            bcnt            <= '0;
            gcnt            <= '0;
            state           <= GAP;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        GAP: begin
          gcnt <= gcnt + GW'(1);
          if (gcnt == G_LAST) begin
            host.HOST_READY <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sci_master.sv
// tb_sci_master: random + directed scoreboard bench for sci_master.
// A behavioural SCI slave decodes frames and answers from its own memory.
module tb_sci_master;
  localparam int TO  = 16;
  localparam int GAP = 4;

  typedef struct {
    logic       wnr;
    logic [7:0] addr;
    logic [7:0] data;
    logic       noack;
    int         dly;
    int         stall;
    logic       seq;
  } frame_t;

  typedef struct {
    logic       wnr;
    logic       err;
    logic [7:0] rdata;
  } exp_t;

  logic clk;
  logic rstn;
  logic sci_csn;
  logic sci_req;
  logic sci_resp;
  logic sci_ack;

  int n_tests;
  int n_fail;

  logic [7:0] ref_mem [256];
  logic [7:0] slv_mem [256];
  logic [7:0] last_rd;
  frame_t     frame_q [$];
  exp_t       sb_q [$];

  sci_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) hif ();

  sci_master #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8),
    .TIMEOUT_CYCLES(TO),
    .GAP_CYCLES(GAP)
  ) dut (
    .CLK(clk),
    .RSTN(rstn),
    .host(hif.slave),
    .SCI_CSN(sci_csn),
    .SCI_REQ(sci_req),
    .SCI_RESP(sci_resp),
    .SCI_ACK(sci_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endtask

  // Behavioural slave: one call per frame, entered on first CSN-low cycle
  task automatic slave_frame();
    frame_t     f;
    logic       cmd;
    logic [7:0] a;
    logic [7:0] d;
    int         k;
    chk("frame_expected", 32'(frame_q.size()), 32'd1);
    if (frame_q.size() == 0) begin
      while (!sci_csn) @(negedge clk);
      return;
    end
    f = frame_q.pop_front();
    cmd = sci_req;
    a = '0;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (sci_csn) return;
      a = {a[6:0], sci_req};
    end
    chk("frame_cmd", 32'(cmd), 32'(f.wnr));
    chk("frame_addr", 32'(a), 32'(f.addr));
    if (cmd) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (sci_csn) return;
        d = {d[6:0], sci_req};
      end
      chk("frame_wdata", 32'(d), 32'(f.data));
    end
    if (f.seq)
      chk("req_sequence", 32'({cmd, a, d}), 32'h13C5A);
    if (f.noack) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!sci_csn && k < 64);
      chk("timeout_latency", 32'(k), 32'(TO + 1));
      return;
    end
    repeat (f.dly) @(negedge clk);
    if (cmd) begin
      sci_ack = 1'b1;
      @(negedge clk);
      sci_ack = 1'b0;
      slv_mem[a] = d;
    end else begin
      for (int i = 7; i >= 0; i--) begin
        sci_resp = slv_mem[a][i];
        sci_ack  = 1'b1;
        @(negedge clk);
        sci_ack  = 1'b0;
        sci_resp = 1'b0;
        if (i > 0) repeat (f.stall) @(negedge clk);
      end
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!sci_csn && k < 64);
    chk("done_latency", 32'(k), 32'd1);
  endtask

  initial begin : slave
    sci_ack  = 1'b0;
    sci_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && !sci_csn) slave_frame();
    end
  end

  initial begin : monitor
    exp_t  e;
    int    k;
    string nm;
    forever begin
      @(negedge clk);
      if (rstn && hif.HOST_DONE) begin
        chk("done_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("done_err", 32'(hif.HOST_ERR), 32'(e.err));
          if (!e.wnr) last_rd = e.rdata;
          nm = e.wnr ? "wr_rdata_hold" : "rd_data";
          chk(nm, 32'(hif.HOST_RDATA), 32'(last_rd));
          chk("done_csn", 32'(sci_csn), 32'd1);
          k = 0;
          do begin
            @(negedge clk);
            k++;
            if (hif.HOST_DONE)
              chk("single_done", 32'(hif.HOST_DONE), 32'd0);
            if (!sci_csn)
              chk("gap_csn", 32'(sci_csn), 32'd1);
          end while (!hif.HOST_READY && k < 64);
          chk("gap_ready", 32'(k), 32'(GAP));
        end
      end
    end
  end

  task automatic issue(input logic wnr, input logic [7:0] addr,
                       input logic [7:0] data, input logic noack,
                       input int dly, input int stall,
                       input logic seq);
    frame_t f;
    exp_t   e;
    int     k;
    hif.HOST_VALID = 1'b1;
    hif.HOST_WNR   = wnr;
    hif.HOST_ADDR  = addr;
    hif.HOST_WDATA = data;
    k = 0;
    while (!hif.HOST_READY && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!hif.HOST_READY) begin
      chk("ready_wait", 32'(hif.HOST_READY), 32'd1);
      hif.HOST_VALID = 1'b0;
      return;
    end
    f.wnr = wnr;
    f.addr = addr;
    f.data = data;
    f.noack = noack;
    f.dly = dly;
    f.stall = stall;
    f.seq = seq;
    frame_q.push_back(f);
    e.wnr = wnr;
    e.err = noack;
    e.rdata = 8'h00;
    if (wnr) begin
      if (!noack) ref_mem[addr] = data;
    end else begin
      e.rdata = noack ? 8'h00 : ref_mem[addr];
    end
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((sb_q.size() != 0 || !hif.HOST_READY) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) chk("drain", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin : driver
    logic [7:0] v;
    logic [7:0] old;
    exp_t       drop;
    n_tests = 0;
    n_fail  = 0;
    last_rd = 8'h00;
    rstn    = 1'b0;
    hif.HOST_VALID = 1'b0;
    hif.HOST_WNR   = 1'b0;
    hif.HOST_ADDR  = 8'h00;
    hif.HOST_WDATA = 8'h00;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      ref_mem[i] = v;
      slv_mem[i] = v;
    end
    ref_mem[8'h81] = 8'hA5;
    slv_mem[8'h81] = 8'hA5;
    ref_mem[8'h42] = 8'h3C;
    slv_mem[8'h42] = 8'h3C;
    repeat (3) @(negedge clk);
    chk("rst_csn", 32'(sci_csn), 32'd1);
    chk("rst_req", 32'(sci_req), 32'd0);
    chk("rst_ready", 32'(hif.HOST_READY), 32'd1);
    chk("rst_done", 32'(hif.HOST_DONE), 32'd0);
    chk("rst_err", 32'(hif.HOST_ERR), 32'd0);
    chk("rst_rdata", 32'(hif.HOST_RDATA), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    issue(1'b1, 8'h3C, 8'h5A, 1'b0, 3, 0, 1'b1);
    hif.HOST_VALID = 1'b0;
    wait_idle();
    issue(1'b0, 8'h81, 8'h00, 1'b0, 5, 0, 1'b0);
    hif.HOST_VALID = 1'b0;
    wait_idle();
    issue(1'b0, 8'h42, 8'h00, 1'b0, 1, 2, 1'b0);
    hif.HOST_VALID = 1'b0;
    wait_idle();
    issue(1'b1, 8'h10, 8'h77, 1'b1, 0, 0, 1'b0);
    hif.HOST_VALID = 1'b0;
    wait_idle();
    issue(1'b0, 8'h81, 8'h00, 1'b1, 0, 0, 1'b0);
    hif.HOST_VALID = 1'b0;
    wait_idle();

    issue(1'b1, 8'h90, 8'hC3, 1'b0, 2, 0, 1'b0);
    issue(1'b0, 8'h90, 8'h00, 1'b0, 4, 1, 1'b0);
    hif.HOST_VALID = 1'b0;
    wait_idle();

    old = ref_mem[8'h77];
    issue(1'b1, 8'h77, 8'h12, 1'b0, 1, 0, 1'b0);
    hif.HOST_VALID = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_csn", 32'(sci_csn), 32'd1);
    chk("midrst_ready", 32'(hif.HOST_READY), 32'd1);
    chk("midrst_done", 32'(hif.HOST_DONE), 32'd0);
    chk("midrst_rdata", 32'(hif.HOST_RDATA), 32'd0);
    rstn = 1'b1;
    drop = sb_q.pop_back();
    ref_mem[8'h77] = old;
    last_rd = 8'h00;
    @(negedge clk);
    issue(1'b1, 8'h00, 8'hFF, 1'b0, 2, 0, 1'b0);
    hif.HOST_VALID = 1'b0;
    wait_idle();
    issue(1'b0, 8'h00, 8'h00, 1'b0, 0, 0, 1'b0);
    hif.HOST_VALID = 1'b0;
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom_range(0, 1)), 8'($urandom),
            8'($urandom), 1'($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 8)),
            int'($urandom_range(0, 3)), 1'b0);
      if ($urandom_range(0, 1) == 1) hif.HOST_VALID = 1'b0;
    end
    hif.HOST_VALID = 1'b0;
    wait_idle();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("frames_empty", 32'(frame_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sci_master.md
# sci_master

Initiator end of the SCI serial control interface. A host issues single register reads and writes through a valid/ready port. The block serialises each one onto SCI_CSN/SCI_REQ, then collects the acknowledge or the serial read data from the SCI_ACK/SCI_RESP lines driven by the addressed SCI slave. It sits in the same CLK domain as the slaves and gives a controller or bus bridge access to every SCI-attached register map.

## Interface
Parameters:
- ADDR_WIDTH, 8, register address bits; must match the slave.
- DATA_WIDTH, 8, register data bits; must match the slave.
- TIMEOUT_CYCLES, 256, maximum cycles to wait for any ACK before aborting; must be ≥1.
- GAP_CYCLES, 4, minimum cycles SCI_CSN stays high between transactions; must be ≥2.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RSTN  in  1  synchronous, active-low reset.
- HOST_VALID  in  1  transaction request.
- HOST_READY  out  1  block can accept a request.
- HOST_WNR  in  1  1 = write, 0 = read.
- HOST_ADDR  in  ADDR_WIDTH  register address.
- HOST_WDATA  in  DATA_WIDTH  write data.
- HOST_DONE  out  1  one-cycle completion pulse.
- HOST_RDATA  out  DATA_WIDTH  read data; valid when HOST_DONE is high on a read.
- HOST_ERR  out  1  timeout flag; valid when HOST_DONE is high.
- SCI_CSN  out  1  active-low select.
- SCI_REQ  out  1  serial command, address and write data.
- SCI_RESP  in  1  serial read data from the slave; tri-stated while SCI_CSN is high.
- SCI_ACK  in  1  slave acknowledge; tri-stated while SCI_CSN is high.

## Operation
- SCI_ACK and SCI_RESP are registered once (ack_q, resp_q) before any use. They are ignored in IDLE and GAP, where they may be Z or X.
- Acceptance: HOST_VALID and HOST_READY high at an edge.
  - HOST_WNR, HOST_ADDR and HOST_WDATA are captured into shadow registers.
  - HOST_READY is low from the next cycle until the block returns to IDLE.
- States:
  - IDLE: CSN=1, REQ=0, READY=1. On acceptance go to CMD.
  - CMD: one cycle, CSN=0, REQ=wnr. Go to ADDR.
  - ADDR: ADDR_WIDTH cycles, REQ = address MSB first. Then go to WDATA (write) or RDATA (read).
  - WDATA: DATA_WIDTH cycles, REQ = write data MSB first. Then go to WACK.
  - WACK: CSN=0, REQ=0. Wait for ack_q=1, then go to GAP with DONE, ERR=0.
  - RDATA: CSN=0, REQ=0.
    - Each cycle with ack_q=1 shifts resp_q into the read shift register at the LSB, so the first bit received ends up as the MSB.
    - After DATA_WIDTH bits, go to GAP with DONE, ERR=0, and HOST_RDATA = the shift register.
  - GAP: CSN=1, REQ=0 for GAP_CYCLES cycles, then IDLE.
- Timeout counter:
  - Cleared on entry to WACK or RDATA.
  - Increments every cycle in WACK or RDATA with ack_q=0.
  - Cleared by every ack_q=1 in RDATA.
  - Reaching TIMEOUT_CYCLES: go to GAP with DONE=1, ERR=1. On a read, HOST_RDATA is set to all-zeros.
- Bit counter: width clog2(max(ADDR_WIDTH, DATA_WIDTH)) + 1. Cleared on each state entry; no wrap-around inside a phase.
- HOST_RDATA holds its value until the next read completes. Writes do not change it.
- HOST_VALID while busy is ignored, not queued.

## Timing
- Reset values: SCI_CSN=1, SCI_REQ=0, HOST_READY=1, HOST_DONE=0, HOST_ERR=0, HOST_RDATA=0; state = IDLE; all counters = 0.
- Reset mid-transaction: SCI_CSN=1 on the first edge with RSTN=0, with no DONE pulse. The slave sees a truncated frame and recovers on the next falling edge of CSN.
- All SCI and HOST outputs are registered, so there are no combinational paths from input to output.
- Cycle numbering, with acceptance at edge 0:
  - SCI_CSN falls at edge 1, with CMD on REQ.
  - Address occupies cycles 2..ADDR_WIDTH+1.
  - Write data occupies cycles ADDR_WIDTH+2..ADDR_WIDTH+DATA_WIDTH+1.
- Completion:
  - HOST_DONE is asserted in the cycle after the completing ack_q (or the timeout); SCI_CSN rises in that same cycle.
  - HOST_READY returns GAP_CYCLES cycles after that.
- Simultaneous ack_q=1 and counter at the limit: the ack wins and ERR=0.

## Test plan
- Write 0x5A to 0x3C; slave model acks 3 cycles after the last data bit.
  - REQ over cycles 1–17 is 1,0,0,1,1,1,1,0,0,0,1,0,1,1,0,1,0.
  - Single DONE with ERR=0; CSN stays high for 4 cycles; then READY=1.
- Read from 0x81; slave returns 0xA5 after an RVALID delay of 5 cycles.
  - REQ is 0 followed by 1,0,0,0,0,0,0,1.
  - HOST_RDATA=0xA5 with ERR=0.
- Read where the slave stalls 2 cycles between ack bits (0x3C) -> HOST_RDATA=0x3C, no timeout.
- No ack (lines held Z) with TIMEOUT_CYCLES=16.
  - Write: DONE with ERR=1 exactly 17 cycles after entering WACK.
  - Read: HOST_RDATA=0x00, ERR=1.
- Back-to-back: HOST_VALID held high for a write then a read.
  - CSN high for ≥4 cycles between frames.
  - Second request accepted only when READY=1; both complete correctly.
- RSTN pulsed low during the ADDR phase -> CSN=1 and READY=1 after reset, no DONE. A following write of 0xFF to 0x00 completes correctly.
